// File: rtl/frame_packer.sv
// Purpose : packs a stream of I_BW-bit samples into LANES-wide words, with group index, lane count and last flag.
// Latency : a word is on data_o one cycle after its final sample transfers, provided the output register is free.
// Backpressure: one completed word can wait in the assembly buffer; while it waits di_rdy is low until the output register drains.
//
// Ports:
//   clk, rst                  - rising-edge clock, asynchronous active-low reset
//   di_en / di_rdy / data_i   - sample valid / ready / signed sample
//   di_last                   - final sample of a sequence; it closes the current word early
//   do_en / do_ready / data_o - packed word valid / ready / data (lane k at [I_BW*k +: I_BW])
//   out_group_num             - word index within the sequence
//   out_count                 - number of valid lanes in data_o
//   out_last                  - the word holds the di_last sample
module frame_packer #(
    parameter int I_BW       = 14,
    parameter int LANES      = 64,
    parameter int NUM_GROUPS = 89
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    di_en,
    output logic                    di_rdy,
    input  logic signed [I_BW-1:0]  data_i,
    input  logic                    di_last,
    output logic                    do_en,
    input  logic                    do_ready,
    output logic [I_BW*LANES-1:0]   data_o,
    output logic [6:0]              out_group_num,
    output logic [6:0]              out_count,
    output logic                    out_last
);

    localparam int PW = $clog2(LANES);
    localparam int WW = I_BW * LANES;

    // assembly side
    logic [PW-1:0] r_ptr;
    logic [WW-1:0] r_asm;        // lanes not yet written are always zero
    logic          r_full;       // r_asm holds a completed word waiting for the output register
    logic [6:0]    r_hold_cnt;
    logic          r_hold_last;
    logic          r_di_rdy;

    // output side
    logic          r_do_en;
    logic [WW-1:0] r_data_o;
    logic [6:0]    r_cnt;
    logic [6:0]    r_grp;
    logic          r_last;
    logic [6:0]    r_next_grp;   // group number the next loaded word will carry

    logic          w_xfer;
    logic          w_complete;
    logic          w_out_free;
    logic          w_load;
    logic          w_full_nxt;
    logic [WW-1:0] w_word;
    logic [6:0]    w_cnt;
    logic [WW-1:0] w_ld_word;
    logic [6:0]    w_ld_cnt;
    logic          w_ld_last;
    logic [6:0]    w_grp_inc;

    assign w_xfer     = di_en & r_di_rdy;
    assign w_complete = w_xfer & ((r_ptr == PW'(LANES - 1)) | di_last);
    // output register can take a word this edge: empty, or being accepted now
    assign w_out_free = ~r_do_en | do_ready;
    // a held word always has priority; while held, di_rdy is low so no new completion can collide
    assign w_load     = w_out_free & (r_full | w_complete);
    assign w_full_nxt = r_full ? ~w_out_free : (w_complete & ~w_out_free);

    // current buffer with the incoming sample dropped into its lane
    always_comb begin
        w_word = r_asm;
        w_word[I_BW*r_ptr +: I_BW] = data_i;
    end

    assign w_cnt     = 7'(r_ptr) + 7'd1;
    assign w_ld_word = r_full ? r_asm       : w_word;
    assign w_ld_cnt  = r_full ? r_hold_cnt  : w_cnt;
    assign w_ld_last = r_full ? r_hold_last : di_last;
    assign w_grp_inc = (r_next_grp == 7'(NUM_GROUPS - 1)) ? 7'd0 : r_next_grp + 7'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_asm       <= '0;
            r_full      <= 1'b0;
            r_hold_cnt  <= '0;
            r_hold_last <= 1'b0;
            r_di_rdy    <= 1'b0;
            r_do_en     <= 1'b0;
            r_data_o    <= '0;
            r_cnt       <= '0;
            r_grp       <= '0;
            r_last      <= 1'b0;
            r_next_grp  <= '0;
        end else begin
            r_full   <= w_full_nxt;
            r_di_rdy <= ~w_full_nxt;

            // assembly buffer
            if (r_full) begin
                if (w_out_free) begin
                    r_asm <= '0;
                end
            end else if (w_xfer) begin
                if (w_complete) begin
                    r_ptr <= '0;
                    if (w_out_free) begin
                        r_asm <= '0;
                    end else begin
                        r_asm       <= w_word;
                        r_hold_cnt  <= w_cnt;
                        r_hold_last <= di_last;
                    end
                end else begin
                    r_asm <= w_word;
                    r_ptr <= r_ptr + PW'(1);
                end
            end

            // output register
            if (w_load) begin
                r_do_en    <= 1'b1;
                r_data_o   <= w_ld_word;
                r_cnt      <= w_ld_cnt;
                r_last     <= w_ld_last;
                r_grp      <= r_next_grp;
                r_next_grp <= w_ld_last ? 7'd0 : w_grp_inc;
            end else if (do_ready) begin
                r_do_en <= 1'b0;
            end
        end
    end

    assign di_rdy        = r_di_rdy;
    assign do_en         = r_do_en;
    assign data_o        = r_data_o;
    assign out_count     = r_cnt;
    assign out_group_num = r_grp;
    assign out_last      = r_last;

endmodule

// File: tb/tb_frame_packer.sv
// Purpose : directed and random stimulus for frame_packer with a word scoreboard.
// Latency : n/a (testbench).
// Backpressure: do_ready is forced or randomised; holds are checked for output stability.
module tb_frame_packer;

    localparam int I_BW = 14;
    localparam int LANES = 64;
    localparam int NG = 89;
    localparam int W = I_BW * LANES;

    typedef struct packed {
        logic [W-1:0] d;
        logic [6:0]   c;
        logic [6:0]   g;
        logic         l;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   di_en;
    logic                   di_rdy;
    logic signed [I_BW-1:0] data_i;
    logic                   di_last;
    logic                   do_en;
    logic                   do_ready;
    logic [W-1:0]           data_o;
    logic [6:0]             out_group_num;
    logic [6:0]             out_count;
    logic                   out_last;

    frame_packer #(.I_BW(I_BW), .LANES(LANES), .NUM_GROUPS(NG)) dut (
        .clk(clk), .rst(rst),
        .di_en(di_en), .di_rdy(di_rdy), .data_i(data_i), .di_last(di_last),
        .do_en(do_en), .do_ready(do_ready), .data_o(data_o),
        .out_group_num(out_group_num), .out_count(out_count), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int stalls = 0;

    exp_t         q[$];
    logic [W-1:0] m_word = '0;
    int           m_ptr = 0;
    int           m_grp = 0;

    logic         rdy_mode = 1'b0;   // 1: randomise do_ready
    logic         rdy_force = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int bad;
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            bad = 0;
            for (int k = LANES - 1; k >= 0; k--)
                if (obs[I_BW*k +: I_BW] !== exp[I_BW*k +: I_BW]) bad = k;
            $error("FAIL %s lane %0d observed=%0h expected=%0h", tag, bad,
                   obs[I_BW*bad +: I_BW], exp[I_BW*bad +: I_BW]);
        end
    endtask

    task automatic model_xfer(input logic [I_BW-1:0] d, input logic last);
        exp_t e;
        m_word[I_BW*m_ptr +: I_BW] = d;
        if (last || m_ptr == LANES - 1) begin
            e.d = m_word;
            e.c = 7'(m_ptr + 1);
            e.g = 7'(m_grp);
            e.l = last;
            q.push_back(e);
            m_grp  = last ? 0 : ((m_grp == NG - 1) ? 0 : m_grp + 1);
            m_word = '0;
            m_ptr  = 0;
        end else begin
            m_ptr++;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_word = '0;
        m_ptr  = 0;
        m_grp  = 0;
    endtask

    // Entered and left at posedge+1; leaves di_en high.
    task automatic send(input logic [I_BW-1:0] d, input logic last);
        int waited = 0;
        logic done = 1'b0;
        di_en   = 1'b1;
        data_i  = d;
        di_last = last;
        while (!done && waited < 3000) begin
            @(negedge clk);
            if (di_rdy) begin
                @(posedge clk);
                #1;
                model_xfer(d, last);
                done = 1'b1;
            end else begin
                waited++;
                stalls++;
            end
        end
        if (!done) chk("send_timeout", 32'(waited), 32'd0);
    endtask

    task automatic idle(input int n);
        di_en   = 1'b0;
        di_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        di_en = 1'b0;
        while (q.size() != 0 && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Output monitor: sampled mid-cycle, where inputs already equal their next-edge values.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    logic [14:0]  prev_side;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk_word("hold_data", data_o, prev_data);
                chk("hold_side", 32'({out_group_num, out_count, out_last}), 32'(prev_side));
            end
            prev_hold = do_en && !do_ready;
            prev_data = data_o;
            prev_side = {out_group_num, out_count, out_last};
            if (do_en && do_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk_word("word_data", data_o, e.d);
                    chk("word_count", 32'(out_count), 32'(e.c));
                    chk("word_group", 32'(out_group_num), 32'(e.g));
                    chk("word_last", 32'(out_last), 32'(e.l));
                end
            end
        end
    end

    initial begin
        logic [I_BW-1:0] v;
        rst = 1'b0; di_en = 1'b0; di_last = 1'b0; data_i = '0; do_ready = 1'b0;
        fork
            forever begin
                @(posedge clk);
                #1;
                do_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_do_en", 32'(do_en), 32'd0);
        chk("rst_di_rdy", 32'(di_rdy), 32'd0);
        chk_word("rst_data_o", data_o, '0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_group", 32'(out_group_num), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(di_rdy), 32'd1);

        // one full word, samples 0..63
        for (int k = 0; k < LANES; k++) send(14'(k), 1'b0);
        chk("w0_do_en", 32'(do_en), 32'd1);
        chk("w0_count", 32'(out_count), 32'd64);
        chk("w0_group", 32'(out_group_num), 32'd0);
        chk("w0_lane63", 32'(data_o[I_BW*63 +: I_BW]), 32'd63);
        drain();

        // continuous stream through a full group wrap
        stalls = 0;
        for (int k = 0; k < NG * LANES + LANES; k++) send(14'(k * 3 + 1), 1'b0);
        chk("stream_stalls", 32'(stalls), 32'd0);
        drain();

        // backpressure: output and assembly buffer both fill
        rdy_force = 1'b0;
        idle(2);
        for (int k = 0; k < 2 * LANES; k++) send(14'(1000 + k), 1'b0);
        chk("bp_di_rdy", 32'(di_rdy), 32'd0);
        chk("bp_do_en", 32'(do_en), 32'd1);
        data_i = 14'h1555;
        repeat (72) @(posedge clk);
        #1;
        chk("bp_still_blocked", 32'(di_rdy), 32'd0);
        chk("bp_pending", 32'(q.size()), 32'd2);
        di_en = 1'b0;
        rdy_force = 1'b1;
        drain();

        // short sequence closed by di_last, then next word restarts at group 0
        v = 14'd7;  send(v, 1'b0);
        v = -14'sd1; send(v, 1'b0);
        v = 14'd3;  send(v, 1'b0);
        v = 14'd2;  send(v, 1'b0);
        v = 14'd9;  send(v, 1'b1);
        chk("part_count", 32'(out_count), 32'd5);
        chk("part_last", 32'(out_last), 32'd1);
        for (int k = 0; k < LANES; k++) send(14'(k + 500), 1'b0);
        drain();

        // reset mid-word
        for (int k = 0; k < 30; k++) send(14'(k + 77), 1'b0);
        di_en = 1'b0;
        rst = 1'b0;
        #2;
        chk("mid_rst_di_rdy", 32'(di_rdy), 32'd0);
        chk("mid_rst_do_en", 32'(do_en), 32'd0);
        model_reset();
        idle(2);
        rst = 1'b1;
        idle(1);

        // reset while a word is pending on the output
        rdy_force = 1'b0;
        idle(2);
        for (int k = 0; k < LANES; k++) send(14'(k + 200), 1'b0);
        di_en = 1'b0;
        chk("pend_do_en", 32'(do_en), 32'd1);
        rst = 1'b0;
        #2;
        chk("pend_rst_do_en", 32'(do_en), 32'd0);
        chk_word("pend_rst_data", data_o, '0);
        chk("pend_rst_group", 32'(out_group_num), 32'd0);
        model_reset();
        idle(2);
        rst = 1'b1;
        rdy_force = 1'b1;
        idle(2);
        for (int k = 0; k < LANES; k++) send(14'(k + 300), 1'b0);
        drain();

        // random valid/ready with occasional early last
        rdy_mode = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(14'($urandom), 1'($urandom_range(0, 127) == 0));
        end
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter: I_BW, 14, sample width in bits.
REQ-002 Parameter: LANES, 64, samples per packed word.
REQ-003 Parameter: NUM_GROUPS, 89, packed words per sequence; out_group_num wraps after NUM_GROUPS-1.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: di_en  input  1  input sample valid.
REQ-007 Port: di_rdy  output  1  input sample ready; a sample transfers on a rising edge with di_en=1 and di_rdy=1.
REQ-008 Port: data_i  input  I_BW  signed input sample.
REQ-009 Port: di_last  input  1  marks the final sample of a sequence; sampled only with a transfer.
REQ-010 Port: do_en  output  1  packed word valid.
REQ-011 Port: do_ready  input  1  downstream accepts the word on a rising edge with do_en=1.
REQ-012 Port: data_o  output  I_BW*LANES  packed word; lane k occupies bits [I_BW*k +: I_BW].
REQ-013 Port: out_group_num  output  7  index of the current packed word within the sequence, 0..NUM_GROUPS-1.
REQ-014 Port: out_count  output  7  number of valid lanes in data_o, 1..LANES.
REQ-015 Port: out_last  output  1  word contains the di_last sample.

Function
REQ-016 Transferred samples SHALL fill lanes in order 0,1,...,LANES-1; the lane pointer SHALL advance by 1 per transfer.
REQ-017 A word SHALL complete on transfer of the sample into lane LANES-1, or on transfer with di_last=1 at any lane.
REQ-018 On a partial completion (di_last, pointer <LANES-1), unfilled lanes SHALL be zero and out_count SHALL equal the pointer+1.
REQ-019 When the output register is empty or is accepted on the same edge (do_en=0 or do_ready=1), a completing transfer at edge t SHALL present the word on data_o with do_en=1 immediately after edge t (latency 1 cycle from the last sample).
REQ-020 Otherwise the completed word SHALL be held in the assembly buffer, di_rdy SHALL be 0, and the word SHALL move to the output register on the first edge with do_en=1 and do_ready=1; di_rdy SHALL return to 1 after that edge.
REQ-021 di_rdy SHALL be 1 whenever the assembly buffer is not holding a completed word; this SHALL be a registered signal.
REQ-022 data_o, out_count, out_group_num and out_last SHALL be stable while do_en=1 and do_ready=0.
REQ-023 do_en SHALL fall after an edge accepting the word unless a new word loads on that same edge.
REQ-024 out_group_num SHALL increment by 1 per word loaded into the output register, wrapping from NUM_GROUPS-1 to 0.
REQ-025 After a word with out_last=1 is loaded, the next word SHALL carry out_group_num=0, regardless of count.
REQ-026 The lane pointer SHALL return to 0 after each completing transfer; a transfer into lane 0 SHALL be accepted on the edge after completion if di_rdy=1.
REQ-027 di_en=1 with di_rdy=0 SHALL have no effect; data_i SHALL NOT be captured.

Reset
REQ-028 While rst=0: do_en=0, di_rdy=0, data_o=0, out_count=0, out_group_num=0, out_last=0, lane pointer=0, assembly buffer cleared.
REQ-029 di_rdy SHALL go to 1 on the first rising edge after rst deasserts.
REQ-030 Reset asserted mid-word or with do_en=1 SHALL discard all partial and pending data immediately.

Verification
REQ-031 Stream samples 0..63, do_ready=1 -> one cycle after sample 63, do_en=1, lane k=k, out_count=64, out_group_num=0.
REQ-032 Stream 89*64+64 samples continuous, do_ready=1 -> out_group_num 0..88, then 0 on word 90; no gaps, di_rdy constant 1.
REQ-033 do_ready=0 for 200 cycles while streaming -> first word held stable, second word assembled, di_rdy=0 after 128th transfer; raising do_ready releases word 1 then word 2 in successive acceptances, no sample lost or duplicated.
REQ-034 5 samples 7,-1,3,2,9 with di_last on 5th -> out_count=5, lanes 0..4 = 7,-1,3,2,9, lanes 5..63=0, out_last=1; next word out_group_num=0.
REQ-035 Assert rst after 30 transfers and again with do_en=1 -> all outputs 0 during reset; next stream restarts at lane 0, out_group_num=0.
REQ-036 Random di_en/do_ready toggling, 10000 samples -> scoreboard matches every lane in order; data_o never changes while do_en=1 and do_ready=0.
